// File: rtl/arp_pkg.sv
// Shared definitions for the ARP receive path: frame field offsets,
// protocol constants, the parser state encoding and byte-select helpers.
package arp_pkg;

  localparam logic [5:0] ETH_TYPE    = 6'd12;
  localparam logic [5:0] ARP_OPER    = 6'd20;
  localparam logic [5:0] ARP_SHA     = 6'd22;
  localparam logic [5:0] ARP_SPA     = 6'd28;
  localparam logic [5:0] ARP_TPA     = 6'd38;
  localparam logic [5:0] ARP_MIN_LEN = 6'd42;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [15:0] OPER_REQUEST  = 16'h0001;
  localparam logic [7:0]  HLEN_ETH      = 8'h06;
  localparam logic [7:0]  PLEN_IPV4     = 8'h04;

  typedef enum logic [1:0] {
    ST_WAIT_GAP = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RECV     = 2'd2,
    ST_DROP     = 2'd3
  } arp_state_e;

  // Byte sel of a MAC address, byte 0 being the most significant.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] sel);
    case (sel)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] sel);
    case (sel)
      2'd0:    ip_byte = ip[31:24];
      2'd1:    ip_byte = ip[23:16];
      2'd2:    ip_byte = ip[15:8];
      2'd3:    ip_byte = ip[7:0];
      default: ip_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/arp_rx_parser.sv
// Byte-serial ARP request detector: validates header fields by byte index and
// publishes the requester's SHA/SPA with a one-cycle ARP_SEND pulse.
module arp_rx_parser
  import arp_pkg::*;
(
  input  logic        ARESET,
  input  logic        CLK_RX,
  input  logic [47:0] MY_MAC,
  input  logic [31:0] MY_IPV4,
  input  logic        DATA_VALID_RX,
  input  logic [7:0]  DATA_RX,
  output logic        ARP_SEND,
  output logic [47:0] SOURCE_MAC,
  output logic [31:0] SOURCE_IP
);

  arp_state_e  state_r;
  logic [5:0]  idx_r;
  logic        bcast_ok_r;
  logic        ucast_ok_r;
  logic [47:0] sha_r;
  logic [31:0] spa_r;

  logic [5:0]  idx_s;
  logic [1:0]  tpa_sel_s;
  logic        bcast_s;
  logic        ucast_s;
  logic        byte_ok_s;
  logic        in_sha_s;
  logic        in_spa_s;
  logic [5:0]  idx_next_s;

  // Per-byte field check; IDLE evaluates the first byte at index 0 with fresh flags.
  always_comb begin
    idx_s      = (state_r == ST_IDLE) ? 6'd0 : idx_r;
    tpa_sel_s  = 2'(idx_s - ARP_TPA);
    bcast_s    = (state_r == ST_IDLE) ? 1'b1 : bcast_ok_r;
    ucast_s    = (state_r == ST_IDLE) ? 1'b1 : ucast_ok_r;
    byte_ok_s  = 1'b1;
    in_sha_s   = (idx_s >= ARP_SHA) && (idx_s < ARP_SPA);
    in_spa_s   = (idx_s >= ARP_SPA) && (idx_s < (ARP_SPA + 6'd4));
    idx_next_s = (idx_s == 6'd63) ? 6'd63 : (idx_s + 6'd1);
    case (idx_s)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
        bcast_s   = bcast_s & (DATA_RX == 8'hFF);
        ucast_s   = ucast_s & (DATA_RX == mac_byte(MY_MAC, idx_s[2:0]));
        byte_ok_s = bcast_s | ucast_s;
      end
      ETH_TYPE:          byte_ok_s = (DATA_RX == ETHERTYPE_ARP[15:8]);
      ETH_TYPE + 6'd1:   byte_ok_s = (DATA_RX == ETHERTYPE_ARP[7:0]);
      ETH_TYPE + 6'd2:   byte_ok_s = (DATA_RX == HTYPE_ETH[15:8]);
      ETH_TYPE + 6'd3:   byte_ok_s = (DATA_RX == HTYPE_ETH[7:0]);
      ETH_TYPE + 6'd4:   byte_ok_s = (DATA_RX == PTYPE_IPV4[15:8]);
      ETH_TYPE + 6'd5:   byte_ok_s = (DATA_RX == PTYPE_IPV4[7:0]);
      ETH_TYPE + 6'd6:   byte_ok_s = (DATA_RX == HLEN_ETH);
      ETH_TYPE + 6'd7:   byte_ok_s = (DATA_RX == PLEN_IPV4);
      ARP_OPER:          byte_ok_s = (DATA_RX == OPER_REQUEST[15:8]);
      ARP_OPER + 6'd1:   byte_ok_s = (DATA_RX == OPER_REQUEST[7:0]);
      ARP_TPA, ARP_TPA + 6'd1, ARP_TPA + 6'd2, ARP_TPA + 6'd3:
                         byte_ok_s = (DATA_RX == ip_byte(MY_IPV4, tpa_sel_s));
      default:           byte_ok_s = 1'b1;
    endcase
  end

  // Parser FSM with shadow capture and registered outputs.
  always_ff @(posedge CLK_RX or posedge ARESET) begin
    if (ARESET) begin
      state_r    <= ST_WAIT_GAP;
      idx_r      <= 6'd0;
      bcast_ok_r <= 1'b0;
      ucast_ok_r <= 1'b0;
      sha_r      <= 48'd0;
      spa_r      <= 32'd0;
      ARP_SEND   <= 1'b0;
      SOURCE_MAC <= 48'd0;
      SOURCE_IP  <= 32'd0;
    end else begin
      ARP_SEND <= 1'b0;
      case (state_r)
        ST_WAIT_GAP: begin
          state_r <= DATA_VALID_RX ? ST_WAIT_GAP : ST_IDLE;
        end
        ST_IDLE: begin
          if (DATA_VALID_RX) begin
            idx_r      <= idx_next_s;
            bcast_ok_r <= bcast_s;
            ucast_ok_r <= ucast_s;
            state_r    <= byte_ok_s ? ST_RECV : ST_DROP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RECV: begin
          if (DATA_VALID_RX) begin
            idx_r      <= idx_next_s;
            bcast_ok_r <= bcast_s;
            ucast_ok_r <= ucast_s;
            sha_r      <= in_sha_s ? {sha_r[39:0], DATA_RX} : sha_r;
            spa_r      <= in_spa_s ? {spa_r[23:0], DATA_RX} : spa_r;
            state_r    <= byte_ok_s ? ST_RECV : ST_DROP;
          end else if (idx_r >= ARP_MIN_LEN) begin
            ARP_SEND   <= 1'b1;
            SOURCE_MAC <= sha_r;
            SOURCE_IP  <= spa_r;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DROP: begin
          state_r <= DATA_VALID_RX ? ST_DROP : ST_IDLE;
        end
        default: begin
          state_r <= ST_WAIT_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed-vector bench for arp_rx_parser: builds frames byte by byte and
// checks pulse timing and captured sender fields against hand-derived values.
module tb_arp_rx_parser;

  localparam logic [47:0] MYMAC  = 48'h020000000001;
  localparam logic [31:0] MYIP   = 32'hC0A8010A;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SHA1   = 48'h001122334455;
  localparam logic [47:0] SHAX   = 48'h66778899AABB;
  localparam logic [47:0] SHAU   = 48'h0A0B0C0D0E0F;

  logic        ARESET;
  logic        CLK_RX;
  logic        DATA_VALID_RX;
  logic [7:0]  DATA_RX;
  logic        ARP_SEND;
  logic [47:0] SOURCE_MAC;
  logic [31:0] SOURCE_IP;

  int          vectors;
  int          miscompares;
  int          pulse_cnt;
  logic [31:0] ip_log [$];
  logic [7:0]  frm [0:95];

  arp_rx_parser dut (
    .ARESET        (ARESET),
    .CLK_RX        (CLK_RX),
    .MY_MAC        (MYMAC),
    .MY_IPV4       (MYIP),
    .DATA_VALID_RX (DATA_VALID_RX),
    .DATA_RX       (DATA_RX),
    .ARP_SEND      (ARP_SEND),
    .SOURCE_MAC    (SOURCE_MAC),
    .SOURCE_IP     (SOURCE_IP)
  );

  initial CLK_RX = 1'b0;
  always #5 CLK_RX = ~CLK_RX;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge CLK_RX) begin
    if (ARP_SEND) begin
      pulse_cnt <= pulse_cnt + 1;
      ip_log.push_back(SOURCE_IP);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa, input logic [15:0] oper, input logic [15:0] etype);
    for (int k = 0; k < 96; k++) frm[k] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      frm[k]      = dst[8*(5-k) +: 8];
      frm[6 + k]  = sha[8*(5-k) +: 8];
      frm[22 + k] = sha[8*(5-k) +: 8];
    end
    frm[12] = etype[15:8];
    frm[13] = etype[7:0];
    frm[14] = 8'h00;
    frm[15] = 8'h01;
    frm[16] = 8'h08;
    frm[17] = 8'h00;
    frm[18] = 8'h06;
    frm[19] = 8'h04;
    frm[20] = oper[15:8];
    frm[21] = oper[7:0];
    for (int k = 0; k < 4; k++) begin
      frm[28 + k] = spa[8*(3-k) +: 8];
      frm[38 + k] = tpa[8*(3-k) +: 8];
    end
  endtask

  // Drives len bytes, optionally pulsing ARESET inside the frame, then drops valid.
  task automatic send(input int len, input int rst_at, input int rst_rel);
    for (int i = 0; i < len; i++) begin
      @(posedge CLK_RX);
      #1;
      DATA_VALID_RX = 1'b1;
      DATA_RX       = frm[i];
      if (i == rst_at) begin
        ARESET = 1'b1;
        #1;
        check_val("rst_clr_mac", {16'd0, SOURCE_MAC}, 64'd0);
        check_val("rst_clr_ip", {32'd0, SOURCE_IP}, 64'd0);
        check_val("rst_clr_send", {63'd0, ARP_SEND}, 64'd0);
      end
      if (i == rst_rel) ARESET = 1'b0;
    end
    @(posedge CLK_RX);
    #1;
    DATA_VALID_RX = 1'b0;
    DATA_RX       = 8'h00;
  endtask

  task automatic end_check(input string tag, input logic exp);
    @(posedge CLK_RX);
    @(negedge CLK_RX);
    check_val(tag, {63'd0, ARP_SEND}, {63'd0, exp});
    @(negedge CLK_RX);
    check_val({tag, "_1cyc"}, {63'd0, ARP_SEND}, 64'd0);
  endtask

  task automatic check_src(input string tag, input logic [47:0] mac, input logic [31:0] ip);
    check_val({tag, "_mac"}, {16'd0, SOURCE_MAC}, {16'd0, mac});
    check_val({tag, "_ip"}, {32'd0, SOURCE_IP}, {32'd0, ip});
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    pulse_cnt     = 0;
    ARESET        = 1'b1;
    DATA_VALID_RX = 1'b0;
    DATA_RX       = 8'h00;
    repeat (3) @(posedge CLK_RX);
    @(negedge CLK_RX);
    check_val("reset_send", {63'd0, ARP_SEND}, 64'd0);
    check_src("reset", 48'd0, 32'd0);
    #1 ARESET = 1'b0;
    repeat (2) @(posedge CLK_RX);

    build(BCAST, SHA1, 32'hC0A80105, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("bcast_pulse", 1'b1);
    check_src("bcast", SHA1, 32'hC0A80105);

    build(BCAST, SHAX, 32'hC0A80177, 32'hC0A8010B, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("bad_tpa", 1'b0);
    check_src("bad_tpa", SHA1, 32'hC0A80105);

    build(BCAST, SHAX, 32'hC0A80177, MYIP, 16'h0002, 16'h0806);
    send(60, -1, -1);
    end_check("oper_reply", 1'b0);

    build(BCAST, SHAX, 32'hC0A80177, MYIP, 16'h0001, 16'h0800);
    send(60, -1, -1);
    end_check("etype_ip", 1'b0);
    check_src("etype_ip", SHA1, 32'hC0A80105);

    build(MYMAC, SHAU, 32'hC0A80107, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("ucast_pulse", 1'b1);
    check_src("ucast", SHAU, 32'hC0A80107);

    build(48'h020000000002, SHAX, 32'hC0A80178, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("ucast_other", 1'b0);
    check_src("ucast_other", SHAU, 32'hC0A80107);

    build(BCAST, SHA1, 32'hC0A80105, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    build(BCAST, SHA1, 32'hC0A80106, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("b2b_second", 1'b1);
    check_val("b2b_pulses", 64'(pulse_cnt), 64'd4);
    check_val("b2b_first_ip", {32'd0, ip_log[ip_log.size() - 2]}, 64'h00000000C0A80105);
    check_src("b2b", SHA1, 32'hC0A80106);

    build(BCAST, SHAX, 32'hC0A80179, MYIP, 16'h0001, 16'h0806);
    send(40, -1, -1);
    end_check("runt", 1'b0);
    check_src("runt", SHA1, 32'hC0A80106);

    build(BCAST, SHAU, 32'hC0A80111, MYIP, 16'h0001, 16'h0806);
    send(80, -1, -1);
    end_check("long_pulse", 1'b1);
    check_src("long", SHAU, 32'hC0A80111);

    build(BCAST, SHAX, 32'hC0A80122, MYIP, 16'h0001, 16'h0806);
    send(60, 25, 30);
    end_check("rst_frame", 1'b0);
    check_src("rst_after", 48'd0, 32'd0);

    build(BCAST, SHA1, 32'hC0A80133, MYIP, 16'h0001, 16'h0806);
    send(60, -1, -1);
    end_check("post_rst_pulse", 1'b1);
    check_src("post_rst", SHA1, 32'hC0A80133);

    repeat (2) @(negedge CLK_RX);
    check_val("total_pulses", 64'(pulse_cnt), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arp_rx_parser.md
# arp_rx_parser

Receive-side ARP request detector in the CLK_RX domain, feeding the ARP response path. It parses a byte-serial Ethernet frame and recognises an ARP request whose target protocol address equals MY_IPV4. On a valid request it emits a one-cycle ARP_SEND pulse and holds the requester's MAC and IPv4 address for the transmit side. Frames start at the destination MAC: preamble and SFD are already stripped, and trailing padding/FCS are ignored.

## Interface
- No parameters.
- ARESET  in  1  reset, asynchronous, active-high
- CLK_RX  in  1  receive byte clock
- MY_MAC  in  48  local MAC; byte 0 = bits [47:40]; stable while a frame is in progress
- MY_IPV4  in  32  local IPv4; byte 0 = bits [31:24]; stable while a frame is in progress
- DATA_VALID_RX  in  1  high for every byte of a frame; low marks the inter-frame gap
- DATA_RX  in  8  frame byte, valid when DATA_VALID_RX=1
- ARP_SEND  out  1  one-cycle pulse: a matching ARP request has completed
- SOURCE_MAC  out  48  sender hardware address (SHA) of the last accepted request
- SOURCE_IP  out  32  sender protocol address (SPA) of the last accepted request

## Operation
- Byte index counter: 6 bits, saturates at 63. Index 0 = first byte with DATA_VALID_RX high after a gap.
- Per-index checks; every multi-byte field is MSB first:
  - 0-5 dest MAC: must be all FF or equal MY_MAC. Track bcast_ok and ucast_ok flags; if both are false after byte 5, fail.
  - 12-13 ethertype 0x0806; 14-15 HTYPE 0x0001; 16-17 PTYPE 0x0800; 18 HLEN 0x06; 19 PLEN 0x04; 20-21 OPER 0x0001.
  - 22-27 SHA captured into shadow register; 28-31 SPA captured into shadow register.
  - 38-41 TPA: must equal the corresponding MY_IPV4 byte.
  - Indices 6-11, 32-37 and 42 onward are ignored.
- FSM states:
  - WAIT_GAP: reset state. Go to IDLE when DATA_VALID_RX=0. A frame already in progress when reset deasserts is discarded.
  - IDLE: when DATA_VALID_RX=1, check byte 0 and go to RECV (or DROP on mismatch), index becomes 1.
  - RECV: check/capture each valid byte and increment the index. A mismatch goes to DROP. On DATA_VALID_RX=0:
    - index ≥ 42: assert ARP_SEND, copy shadow SHA/SPA to SOURCE_MAC/SOURCE_IP, go to IDLE.
    - index < 42 (runt): go to IDLE with no pulse and outputs unchanged.
  - DROP: ignore bytes; go to IDLE on DATA_VALID_RX=0.
- SOURCE_MAC/SOURCE_IP change only on an accepted request and hold until the next one. Shadow registers never drive the outputs directly.
- Reset values: ARP_SEND=0, SOURCE_MAC=0, SOURCE_IP=0, state=WAIT_GAP, index=0, shadows=0.

## Timing
- All outputs are registered.
- ARP_SEND goes high in the cycle after the first cycle with DATA_VALID_RX=0 following an accepted frame. It is high for exactly one cycle, and SOURCE_* are updated in that same cycle.
- Minimum gap is one cycle. A new frame may start in the cycle ARP_SEND is high and is parsed normally.
- Back-to-back accepted requests produce separate pulses, and SOURCE_* take the latest values.
- A mismatch at any checked byte means no pulse for that frame; the next frame is unaffected.
- ARESET mid-frame: outputs clear immediately, no pulse; parsing resumes only after a gap.
- Frames longer than 63 bytes: the index stays at 63, and acceptance is unaffected.

## Structure
- Shared package arp_pkg holds:
  - field offsets: ETH_TYPE=12, ARP_OPER=20, ARP_SHA=22, ARP_SPA=28, ARP_TPA=38, ARP_MIN_LEN=42;
  - constants: ETHERTYPE_ARP=16'h0806, HTYPE_ETH=16'h0001, PTYPE_IPV4=16'h0800, OPER_REQUEST=16'h0001;
  - the FSM state enum.
- No sub-module. Checks are a case on the byte index inside one module; the output side reuses the arp_pkg constants.

## Test plan
- MY_IPV4=C0A8010A, MY_MAC=02:00:00:00:00:01. Broadcast request from SHA 00:11:22:33:44:55, SPA C0A80105, TPA C0A8010A, 60 bytes -> one ARP_SEND pulse one cycle after valid falls, SOURCE_MAC=001122334455, SOURCE_IP=C0A80105.
- Same frame with TPA C0A8010B, or OPER 0x0002, or ethertype 0x0800 -> no pulse, outputs keep their previous values.
- Unicast destination 02:00:00:00:00:01 accepted. Destination 02:00:00:00:00:02 -> no pulse.
- Two accepted requests separated by a one-cycle gap, SPA C0A80105 then C0A80106 -> two pulses; SOURCE_IP ends at C0A80106.
- Runt frame truncated at byte 40 -> no pulse.
- ARESET asserted at byte 25 and released at byte 30 -> outputs 0, the remainder of that frame is ignored, and the next valid request is accepted.
